// File: rtl/dmem_if.sv
// Data memory request/response bus.
// Master issues loads/stores; slave answers one cycle later.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_funct3, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_funct3, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I data memory controller: zeroing sweep after reset,
// then byte/half/word loads and stores with one-cycle response.
module dmem_ctrl #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output logic   busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy          = 1'b0;
    bus.req_ready = 1'b0;
    unique case (state_q)
      INIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1))
          state_d = RUN;
      end
      RUN: bus.req_ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          oor, mis, ill, err;
  logic          is_b, is_h, is_w, uns;
  logic          acc, wr;

  assign off  = bus.req_addr - BASE_ADDR;
  assign idx  = off[AW+1:2];
  assign lane = off[1:0];
  assign oor  = |off[31:AW+2];

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    uns  = 1'b0;
    ill  = 1'b0;
    unique case (bus.req_funct3)
      3'b000: is_b = 1'b1;
      3'b001: is_h = 1'b1;
      3'b010: is_w = 1'b1;
      3'b100: begin
        is_b = 1'b1;
        uns  = 1'b1;
      end
      3'b101: begin
        is_h = 1'b1;
        uns  = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // unsigned sizes only exist for loads
    if (uns && bus.req_we)
      ill = 1'b1;
  end

  assign mis = (is_h & off[0]) | (is_w & |off[1:0]);
  assign err = oor | mis | ill;
  assign acc = bus.req_valid & bus.req_ready;
  assign wr  = acc & bus.req_we & ~err;

  logic [31:0] rd_word, rd_sh, ld;
  logic [31:0] mask, wdat;

  assign rd_word = mem[idx];
  assign rd_sh   = rd_word >> {lane, 3'b000};

  always_comb begin
    mask = '1;
    wdat = bus.req_wdata;
    ld   = rd_word;
    unique case (1'b1)
      is_b: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        wdat = {4{bus.req_wdata[7:0]}};
        ld   = uns ? {24'h0, rd_sh[7:0]}
                   : {{24{rd_sh[7]}}, rd_sh[7:0]};
      end
      is_h: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        wdat = {2{bus.req_wdata[15:0]}};
        ld   = uns ? {16'h0, rd_sh[15:0]}
                   : {{16{rd_sh[15]}}, rd_sh[15:0]};
      end
      default: ;
    endcase
  end

  // single write port shared by the sweep and stores
  always_ff @(posedge clk) begin
    if (state_q == INIT)
      mem[cnt_q] <= '0;
    else if (wr)
      mem[idx] <= (rd_word & ~mask) | (wdat & mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= acc;
      bus.resp_err   <= acc & err;
      bus.resp_rdata <= (acc & ~err & ~bus.req_we)
                        ? ld : '0;
    end
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 256, data memory size in 32-bit words (power of two, 4..4096).
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle if req_valid also high.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port resp_rdata  output  32  load result, extended to 32 bits.
REQ-013 SHALL have port resp_err  output  1  request was rejected (misaligned, out of range, or illegal funct3).
REQ-014 SHALL have port busy  output  1  initialisation sweep in progress.

Function
REQ-015 SHALL implement FSM states INIT and RUN; rst forces INIT with sweep counter 0.
REQ-016 In INIT, SHALL write 32'h0 to word[counter] each cycle, increment counter, and enter RUN after clearing word DEPTH-1 (exactly DEPTH cycles after rst deasserts).
REQ-017 SHALL hold busy=1 and req_ready=0 in INIT; busy=0 and req_ready=1 in RUN.
REQ-018 Acceptance = req_valid & req_ready; SHALL produce exactly one resp_valid pulse in the cycle after each acceptance, supporting back-to-back requests every cycle.
REQ-019 Offset = req_addr - BASE_ADDR (32-bit wrap); word index = offset[log2(DEPTH)+1:2]; out of range when offset >= 4*DEPTH.
REQ-020 Misaligned = (H/HU and offset[0]=1) or (W and offset[1:0]!=0).
REQ-021 Illegal = funct3 in {011, 110, 111}, or funct3 in {100, 101} with req_we=1.
REQ-022 Any error SHALL suppress the write, give resp_err=1 and resp_rdata=0.
REQ-023 SB SHALL write byte lane offset[1:0] with wdata[7:0]; SH lanes {1,0} or {3,2} by offset[1] with wdata[15:0]; SW all four lanes; unwritten lanes unchanged.
REQ-024 Stores SHALL give resp_rdata=0, resp_err=0.
REQ-025 Loads SHALL read the word at acceptance, select lane(s) by offset, sign-extend for B/H and zero-extend for BU/HU, and return W unchanged.
REQ-026 A load accepted the cycle after a store to the same word SHALL return post-store data; no forwarding within a single cycle is needed as one request per cycle is accepted.
REQ-027 resp_valid, resp_rdata, resp_err SHALL be registered outputs.

Reset
REQ-028 On rst: resp_valid=0, resp_rdata=0, resp_err=0, busy=1, req_ready=0, state INIT, counter 0.
REQ-029 rst asserted mid-sweep or mid-request SHALL discard any pending response and restart the sweep from word 0.
REQ-030 Memory contents SHALL read 0 for every word after the sweep completes.

Verification
REQ-031 Reset release, DEPTH=256 -> busy=1 and req_ready=0 for 256 cycles, then busy=0; LW at every word returns 0.
REQ-032 SW 0x8000_00FF at offset 0x10, then LB/LBU at 0x10 -> 0xFFFF_FFFF/0x0000_00FF; LH/LHU at 0x12 -> 0xFFFF_8000/0x0000_8000.
REQ-033 SW 0x1122_3344 at 0x20, SB 0xAA at 0x21, SH 0xBEEF at 0x22, LW 0x20 -> 0xBEEF_AA44, all responses err=0.
REQ-034 LW at 0x02, SH at 0x05, load at offset 0x400 (DEPTH=256), funct3=011 -> resp_err=1, rdata=0, memory unchanged.
REQ-035 Back-to-back SW 0x5 at 0x40 then LW 0x40 on consecutive cycles -> two resp_valid pulses, second rdata=0x0000_0005.
REQ-036 rst pulsed at sweep cycle 100 and again one cycle after a load is accepted -> no resp_valid for that load; sweep restarts, busy high 256 more cycles.
